// File: rtl/axi4_mem_pkg.sv
// Shared response codes, FSM state types and the INCR beat-address step
// used by the on-chip AXI4 memory responder.
package axi4_mem_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [0:0] {
    R_IDLE  = 1'b0,
    R_BURST = 1'b1
  } r_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  // INCR burst: the next beat sits (1 << size) bytes further on.
  function automatic logic [31:0] beat_next_addr(input logic [31:0] addr,
                                                 input logic [2:0]  size);
    return addr + (32'd1 << size);
  endfunction

endpackage

// File: rtl/axi4_mem_array.sv
// Word-wide storage with one byte-strobed write port and one registered read
// port; the read register loads only when rd_en is high.
module axi4_mem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int DATA_BITS   = 64,
  localparam int STRB_BITS  = DATA_BITS / 8,
  localparam int IDX_BITS   = $clog2(DEPTH_WORDS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [IDX_BITS-1:0]  wr_idx,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic [STRB_BITS-1:0] wr_strb,
  input  logic                 rd_en,
  input  logic                 rd_zero,
  input  logic [IDX_BITS-1:0]  rd_idx,
  output logic [DATA_BITS-1:0] rd_data
);

  logic [DATA_BITS-1:0] mem [DEPTH_WORDS];

  // Storage is deliberately left out of reset so contents survive it.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int b = 0; b < STRB_BITS; b++) begin
        if (wr_strb[b]) begin
          mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  // Read register: an out-of-range beat loads zero instead of a word.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_zero ? '0 : mem[rd_idx];
    end else begin
      rd_data <= rd_data;
    end
  end

endmodule

// File: rtl/axi4_mem_responder.sv
// AXI4 memory responder: independent read and write FSMs, one outstanding
// INCR burst each, backed by axi4_mem_array with fixed handshake latency.
module axi4_mem_responder
  import axi4_mem_pkg::*;
#(
  parameter int ADDR_BITS   = 16,
  parameter int DATA_BITS   = 64,
  parameter int ID_BITS     = 4,
  parameter int DEPTH_WORDS = 1024,
  localparam int STRB_BITS  = DATA_BITS / 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ar_valid,
  output logic                 ar_ready,
  input  logic [ADDR_BITS-1:0] ar_bits_addr,
  input  logic [ID_BITS-1:0]   ar_bits_id,
  input  logic [2:0]           ar_bits_size,
  input  logic [7:0]           ar_bits_len,
  output logic                 r_valid,
  input  logic                 r_ready,
  output logic [DATA_BITS-1:0] r_bits_data,
  output logic [ID_BITS-1:0]   r_bits_id,
  output logic [1:0]           r_bits_resp,
  output logic                 r_bits_last,
  input  logic                 aw_valid,
  output logic                 aw_ready,
  input  logic [ADDR_BITS-1:0] aw_bits_addr,
  input  logic [ID_BITS-1:0]   aw_bits_id,
  input  logic [2:0]           aw_bits_size,
  input  logic [7:0]           aw_bits_len,
  input  logic                 w_valid,
  output logic                 w_ready,
  input  logic [DATA_BITS-1:0] w_bits_data,
  input  logic [STRB_BITS-1:0] w_bits_strb,
  input  logic                 w_bits_last,
  output logic                 b_valid,
  input  logic                 b_ready,
  output logic [ID_BITS-1:0]   b_bits_id,
  output logic [1:0]           b_bits_resp
);

  localparam int OFF_BITS = $clog2(STRB_BITS);
  localparam int IDX_BITS = $clog2(DEPTH_WORDS);

  r_state_t             r_state;
  w_state_t             w_state;
  logic [ADDR_BITS-1:0] r_addr, w_addr, r_next_addr, w_next_addr, rd_addr;
  logic [2:0]           r_size, w_size;
  logic [7:0]           r_len, r_beat, w_len, w_beat;
  logic                 w_err, w_err_next, w_final, rd_en, wr_en;

  function automatic logic in_range(input logic [ADDR_BITS-1:0] a);
    return (32'(a) >> OFF_BITS) < 32'(DEPTH_WORDS);
  endfunction

  function automatic logic [IDX_BITS-1:0] word_idx(input logic [ADDR_BITS-1:0] a);
    return a[OFF_BITS +: IDX_BITS];
  endfunction

  // Ready is held low while reset is asserted even though the state is idle.
  assign ar_ready    = (r_state == R_IDLE) && !reset;
  assign aw_ready    = (w_state == W_IDLE) && !reset;
  assign w_ready     = (w_state == W_DATA);
  assign b_valid     = (w_state == W_RESP);
  assign r_next_addr = ADDR_BITS'(beat_next_addr(32'(r_addr), r_size));
  assign w_next_addr = ADDR_BITS'(beat_next_addr(32'(w_addr), w_size));
  assign w_final     = (w_beat == w_len);
  assign w_err_next  = w_err || !in_range(w_addr) || (w_bits_last != w_final);
  assign wr_en       = (w_state == W_DATA) && w_valid && in_range(w_addr) && !reset;

  // Read register loads on the AR handshake and on each non-final R handshake.
  always_comb begin
    rd_en   = 1'b0;
    rd_addr = r_next_addr;
    if (ar_valid && ar_ready) begin
      rd_en   = 1'b1;
      rd_addr = ar_bits_addr;
    end else if (r_valid && r_ready && !r_bits_last) begin
      rd_en   = 1'b1;
      rd_addr = r_next_addr;
    end else begin
      rd_en   = 1'b0;
      rd_addr = r_next_addr;
    end
  end

  axi4_mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .DATA_BITS  (DATA_BITS)
  ) u_array (
    .clock  (clock),
    .reset  (reset),
    .wr_en  (wr_en),
    .wr_idx (word_idx(w_addr)),
    .wr_data(w_bits_data),
    .wr_strb(w_bits_strb),
    .rd_en  (rd_en),
    .rd_zero(!in_range(rd_addr)),
    .rd_idx (word_idx(rd_addr)),
    .rd_data(r_bits_data)
  );

  // Read FSM with registered R channel sideband.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= R_IDLE;
      r_valid     <= 1'b0;
      r_bits_id   <= '0;
      r_bits_resp <= RESP_OKAY;
      r_bits_last <= 1'b0;
      r_addr      <= '0;
      r_size      <= 3'd0;
      r_len       <= 8'd0;
      r_beat      <= 8'd0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_valid) begin
            r_state     <= R_BURST;
            r_valid     <= 1'b1;
            r_bits_id   <= ar_bits_id;
            r_bits_resp <= in_range(ar_bits_addr) ? RESP_OKAY : RESP_SLVERR;
            r_bits_last <= (ar_bits_len == 8'd0);
            r_addr      <= ar_bits_addr;
            r_size      <= ar_bits_size;
            r_len       <= ar_bits_len;
            r_beat      <= 8'd0;
          end
        end
        R_BURST: begin
          if (r_ready && r_bits_last) begin
            r_state <= R_IDLE;
            r_valid <= 1'b0;
          end else if (r_ready) begin
            r_addr      <= r_next_addr;
            r_beat      <= r_beat + 8'd1;
            r_bits_resp <= in_range(r_next_addr) ? RESP_OKAY : RESP_SLVERR;
            r_bits_last <= ((r_beat + 8'd1) == r_len);
          end
        end
        default: begin
          r_state <= R_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  // Write FSM: burst length comes from AW; a stray or missing w_last only flags error.
  always_ff @(posedge clock) begin
    if (reset) begin
      w_state     <= W_IDLE;
      w_addr      <= '0;
      w_size      <= 3'd0;
      w_len       <= 8'd0;
      w_beat      <= 8'd0;
      w_err       <= 1'b0;
      b_bits_id   <= '0;
      b_bits_resp <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_valid) begin
            w_state   <= W_DATA;
            w_addr    <= aw_bits_addr;
            w_size    <= aw_bits_size;
            w_len     <= aw_bits_len;
            w_beat    <= 8'd0;
            w_err     <= 1'b0;
            b_bits_id <= aw_bits_id;
          end
        end
        W_DATA: begin
          if (w_valid && w_final) begin
            w_state     <= W_RESP;
            w_err       <= w_err_next;
            b_bits_resp <= w_err_next ? RESP_SLVERR : RESP_OKAY;
          end else if (w_valid) begin
            w_addr <= w_next_addr;
            w_beat <= w_beat + 8'd1;
            w_err  <= w_err_next;
          end
        end
        W_RESP: begin
          if (b_ready) begin
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_mem_responder.sv
// Directed-plus-random bench for axi4_mem_responder, checked against a
// byte-addressed memory model and the burst rules of the responder.
module tb_axi4_mem_responder;

  localparam int DEPTH = 1024;

  logic        clock = 1'b0;
  logic        reset;
  logic        ar_valid, ar_ready, r_valid, r_ready, r_bits_last;
  logic [15:0] ar_bits_addr, aw_bits_addr;
  logic [3:0]  ar_bits_id, aw_bits_id, r_bits_id, b_bits_id;
  logic [2:0]  ar_bits_size, aw_bits_size;
  logic [7:0]  ar_bits_len, aw_bits_len, w_bits_strb;
  logic [63:0] r_bits_data, w_bits_data;
  logic [1:0]  r_bits_resp, b_bits_resp;
  logic        aw_valid, aw_ready, w_valid, w_ready, w_bits_last;
  logic        b_valid, b_ready;

  logic [7:0]  mdl [DEPTH*8];
  logic [63:0] wd [256];
  logic [7:0]  ws [256];
  int          checks = 0;
  int          errors = 0;

  axi4_mem_responder dut (
    .clock(clock), .reset(reset),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_bits_addr(ar_bits_addr),
    .ar_bits_id(ar_bits_id), .ar_bits_size(ar_bits_size), .ar_bits_len(ar_bits_len),
    .r_valid(r_valid), .r_ready(r_ready), .r_bits_data(r_bits_data),
    .r_bits_id(r_bits_id), .r_bits_resp(r_bits_resp), .r_bits_last(r_bits_last),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_bits_addr(aw_bits_addr),
    .aw_bits_id(aw_bits_id), .aw_bits_size(aw_bits_size), .aw_bits_len(aw_bits_len),
    .w_valid(w_valid), .w_ready(w_ready), .w_bits_data(w_bits_data),
    .w_bits_strb(w_bits_strb), .w_bits_last(w_bits_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_bits_id(b_bits_id), .b_bits_resp(b_bits_resp)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit in_rng(input int a);
    return (a >> 3) < DEPTH;
  endfunction

  function automatic logic [63:0] exp_word(input int a);
    logic [63:0] w = 64'd0;
    if (in_rng(a)) begin
      for (int b = 0; b < 8; b++) w[b*8 +: 8] = mdl[(a >> 3)*8 + b];
    end
    return w;
  endfunction

  task automatic model_write(input int a, input logic [63:0] d, input logic [7:0] s);
    for (int b = 0; b < 8; b++) begin
      if (s[b]) mdl[(a >> 3)*8 + b] = d[b*8 +: 8];
    end
  endtask

  // Writes beats wd/ws[0..len]; w_last is driven on beat index last_at.
  task automatic do_write(input int addr, input int size, input int len, input int id,
                          input int last_at, input bit gaps);
    int t = 0;
    int a;
    bit err = 1'b0;
    @(negedge clock);
    aw_valid = 1'b1; aw_bits_addr = 16'(addr); aw_bits_id = 4'(id);
    aw_bits_size = 3'(size); aw_bits_len = 8'(len);
    while (!aw_ready && t < 20) begin @(negedge clock); t++; end
    check("aw_ready_wait", 64'(aw_ready), 64'd1);
    @(negedge clock);
    aw_valid = 1'b0;
    check("w_ready_after_aw", 64'(w_ready), 64'd1);
    for (int i = 0; i <= len; i++) begin
      while (gaps && $urandom_range(3) == 0) begin w_valid = 1'b0; @(negedge clock); end
      w_valid = 1'b1; w_bits_data = wd[i]; w_bits_strb = ws[i];
      w_bits_last = (i == last_at);
      a = (addr + i * (1 << size)) & 32'hFFFF;
      if (in_rng(a)) model_write(a, wd[i], ws[i]);
      else err = 1'b1;
      if ((i == last_at) != (i == len)) err = 1'b1;
      @(negedge clock);
    end
    w_valid = 1'b0; w_bits_last = 1'b0;
    check("b_valid_after_last_w", 64'(b_valid), 64'd1);
    check("w_ready_in_resp", 64'(w_ready), 64'd0);
    check("b_id", 64'(b_bits_id), 64'(id));
    check("b_resp", 64'(b_bits_resp), err ? 64'd2 : 64'd0);
    repeat ($urandom_range(2)) @(negedge clock);
    check("b_valid_held", 64'(b_valid), 64'd1);
    b_ready = 1'b1;
    @(negedge clock);
    b_ready = 1'b0;
    check("aw_ready_after_b", 64'(aw_ready), 64'd1);
    check("b_valid_after_b", 64'(b_valid), 64'd0);
  endtask

  task automatic do_read(input int addr, input int size, input int len, input int id,
                         input bit rand_ready);
    int t = 0;
    int i = 0;
    int a;
    @(negedge clock);
    ar_valid = 1'b1; ar_bits_addr = 16'(addr); ar_bits_id = 4'(id);
    ar_bits_size = 3'(size); ar_bits_len = 8'(len); r_ready = 1'b0;
    while (!ar_ready && t < 20) begin @(negedge clock); t++; end
    check("ar_ready_wait", 64'(ar_ready), 64'd1);
    @(negedge clock);
    ar_valid = 1'b0;
    check("r_valid_after_ar", 64'(r_valid), 64'd1);
    t = 0;
    while (i <= len && t < 4000) begin
      a = (addr + i * (1 << size)) & 32'hFFFF;
      check("r_valid", 64'(r_valid), 64'd1);
      check("r_data", r_bits_data, exp_word(a));
      check("r_resp", 64'(r_bits_resp), in_rng(a) ? 64'd0 : 64'd2);
      check("r_last", 64'(r_bits_last), (i == len) ? 64'd1 : 64'd0);
      check("r_id", 64'(r_bits_id), 64'(id));
      r_ready = rand_ready ? 1'($urandom_range(1)) : 1'b1;
      @(negedge clock);
      t++;
      if (r_ready) i++;
    end
    r_ready = 1'b0;
    check("r_beat_count", 64'(i), 64'(len + 1));
    check("ar_ready_after_last_r", 64'(ar_ready), 64'd1);
    check("r_valid_after_last_r", 64'(r_valid), 64'd0);
  endtask

  task automatic check_idle_after_reset();
    check("rst_ar_ready", 64'(ar_ready), 64'd1);
    check("rst_aw_ready", 64'(aw_ready), 64'd1);
    check("rst_r_valid", 64'(r_valid), 64'd0);
    check("rst_w_ready", 64'(w_ready), 64'd0);
    check("rst_b_valid", 64'(b_valid), 64'd0);
    check("rst_r_data", r_bits_data, 64'd0);
  endtask

  initial begin
    int addr, size, len;
    reset = 1'b1;
    ar_valid = 1'b0; ar_bits_addr = 16'd0; ar_bits_id = 4'd0; ar_bits_size = 3'd0; ar_bits_len = 8'd0;
    aw_valid = 1'b0; aw_bits_addr = 16'd0; aw_bits_id = 4'd0; aw_bits_size = 3'd0; aw_bits_len = 8'd0;
    w_valid = 1'b0; w_bits_data = 64'd0; w_bits_strb = 8'd0; w_bits_last = 1'b0;
    r_ready = 1'b0; b_ready = 1'b0;

    // Reset values while reset is held, then on the first cycle after.
    repeat (3) @(negedge clock);
    check("in_rst_ar_ready", 64'(ar_ready), 64'd0);
    check("in_rst_aw_ready", 64'(aw_ready), 64'd0);
    check("in_rst_r_valid", 64'(r_valid), 64'd0);
    check("in_rst_b_valid", 64'(b_valid), 64'd0);
    check("in_rst_r_id", 64'(r_bits_id), 64'd0);
    check("in_rst_b_resp", 64'(b_bits_resp), 64'd0);
    reset = 1'b0;
    #1;
    check_idle_after_reset();

    // Fill all of storage so every later read has a defined expectation.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 256; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
      do_write(k * 2048, 3, 255, k, 255, 1'b0);
    end

    // Single-beat write then read of word 0.
    wd[0] = 64'h0123_4567_89AB_CDEF; ws[0] = 8'hFF;
    do_write(0, 3, 0, 1, 0, 1'b0);
    do_read(0, 3, 0, 2, 1'b0);
    check("word0_const", exp_word(0), 64'h0123_4567_89AB_CDEF);

    // Partial strobe on beat 2 of a 4-beat burst.
    for (int i = 0; i < 4; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
    ws[1] = 8'h0F;
    do_write(16'h40, 3, 3, 3, 3, 1'b1);
    do_read(16'h40, 3, 3, 4, 1'b0);

    // Long read with random back-pressure.
    do_read(16'h800, 3, 255, 7, 1'b1);

    // Burst running off the end of storage.
    wd[0] = {$urandom, $urandom}; wd[1] = {$urandom, $urandom}; ws[0] = 8'hFF; ws[1] = 8'hFF;
    do_write(DEPTH*8 - 8, 3, 1, 8, 1, 1'b0);
    do_read(DEPTH*8 - 8, 3, 1, 9, 1'b0);

    // Early w_last: all four beats still taken, error response.
    for (int i = 0; i < 4; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
    do_write(16'h300, 3, 3, 10, 1, 1'b0);
    do_read(16'h300, 3, 3, 11, 1'b0);

    // Random narrow and wide bursts, some crossing the top of storage.
    for (int n = 0; n < 8; n++) begin
      size = $urandom_range(3);
      len  = $urandom_range(7);
      addr = $urandom_range(16'h2040) & ~((1 << size) - 1);
      for (int i = 0; i <= len; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'($urandom); end
      do_write(addr, size, len, n, len, 1'b1);
      do_read(addr, size, len, 15 - n, 1'b1);
    end

    // Reset in the middle of concurrent read and write bursts.
    @(negedge clock);
    ar_valid = 1'b1; ar_bits_addr = 16'h0100; ar_bits_id = 4'h5; ar_bits_size = 3'd3; ar_bits_len = 8'd7;
    aw_valid = 1'b1; aw_bits_addr = 16'h0200; aw_bits_id = 4'h6; aw_bits_size = 3'd3; aw_bits_len = 8'd3;
    #1;
    check("mid_ar_ready", 64'(ar_ready), 64'd1);
    check("mid_aw_ready", 64'(aw_ready), 64'd1);
    @(negedge clock);
    ar_valid = 1'b0; aw_valid = 1'b0;
    check("mid_r_valid", 64'(r_valid), 64'd1);
    check("mid_w_ready", 64'(w_ready), 64'd1);
    check("mid_r_data0", r_bits_data, exp_word(16'h100));
    r_ready = 1'b1; w_valid = 1'b1; w_bits_data = 64'hDEAD_BEEF_0BAD_F00D; w_bits_strb = 8'hFF;
    model_write(16'h200, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF);
    @(negedge clock);
    check("mid_r_data1", r_bits_data, exp_word(16'h108));
    r_ready = 1'b0; w_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_r_valid", 64'(r_valid), 64'd0);
    check("mid_rst_w_ready", 64'(w_ready), 64'd0);
    check("mid_rst_ar_ready", 64'(ar_ready), 64'd0);
    check("mid_rst_r_data", r_bits_data, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_idle_after_reset();
    do_read(16'h200, 3, 3, 12, 1'b0);
    do_read(16'h100, 3, 7, 13, 1'b1);
    do_read(0, 3, 0, 14, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi4_mem_responder.md
# axi4_mem_responder

Synthesizable AXI4 responder that terminates one FPGA-initiated memory channel (the `mem_N` interface of `FPGATop`) with on-chip storage, replacing the software memory model for small-footprint and gate-level simulations. It accepts INCR read and write bursts, honours write strobes, and returns `r`/`b` responses with fixed, cycle-exact latency. Read and write paths are independent, with one outstanding burst each.

## Interface
- `ADDR_BITS`, 16: width of `ar_bits_addr` / `aw_bits_addr`.
- `DATA_BITS`, 64: data width; power of two, ≥ 8; `STRB_BITS = DATA_BITS/8`.
- `ID_BITS`, 4: AXI ID width.
- `DEPTH_WORDS`, 1024: storage depth in `DATA_BITS` words; power of two; `DEPTH_WORDS*STRB_BITS` ≤ 2^ADDR_BITS.

- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `ar_valid`, `ar_ready`  in/out  1  read-address handshake.
- `ar_bits_addr`  in  ADDR_BITS  byte address; `ar_bits_id` in ID_BITS; `ar_bits_size` in 3; `ar_bits_len` in 8 (beats−1).
- `r_valid`  out  1; `r_ready` in 1; `r_bits_data` out DATA_BITS; `r_bits_id` out ID_BITS; `r_bits_resp` out 2; `r_bits_last` out 1.
- `aw_valid`, `aw_ready`  in/out  1; `aw_bits_addr` in ADDR_BITS; `aw_bits_id` in ID_BITS; `aw_bits_size` in 3; `aw_bits_len` in 8.
- `w_valid` in 1; `w_ready` out 1; `w_bits_data` in DATA_BITS; `w_bits_strb` in STRB_BITS; `w_bits_last` in 1.
- `b_valid` out 1; `b_ready` in 1; `b_bits_id` out ID_BITS; `b_bits_resp` out 2.

## Operation
- Read FSM: `R_IDLE` → (AR handshake) → `R_BURST` → (R handshake with `r_bits_last`) → `R_IDLE`. `ar_ready` = state is `R_IDLE`.
- Write FSM: `W_IDLE` → (AW handshake) → `W_DATA` → (W handshake on beat len+1) → `W_RESP` → (B handshake) → `W_IDLE`. `aw_ready` = `W_IDLE`; `w_ready` = `W_DATA`; `b_valid` = `W_RESP`.
- Beat address: starts at the request address, advances by `1 << size` bytes per beat (INCR only; burst type not carried). Word index = `addr >> log2(STRB_BITS)`, no wrap at 4 KiB.
- Out-of-range beat (word index ≥ `DEPTH_WORDS`): read returns data 0, resp `SLVERR` (2'b10) for that beat; write beat dropped, burst marked error.
- Writes commit on the W handshake edge, only bytes with strobe set. Narrow reads return the full addressed word.
- Write burst length is set by `aw_bits_len`; `w_bits_last` not matching beat len+1 marks the burst error but does not shorten or extend it. `b_bits_resp` = `SLVERR` if burst marked error, else `OKAY`.
- `r_bits_id` / `b_bits_id` echo the captured request ID; `r_bits_last` high only on beat len+1.
- `r_bits_data` is registered and stable while `r_valid && !r_ready`; a word is read into the data register on the AR handshake and on each non-final R handshake. A write committing in the same cycle as that load is not visible in the loaded data.
- Read/write to same word from concurrent bursts: no ordering guarantee beyond the rule above.
- Reset mid-burst: both FSMs return to idle; in-flight bursts abandoned; storage contents preserved (not cleared).

## Timing
- While `reset` is high and on the first cycle after it falls: `r_valid`, `b_valid`, `w_ready` = 0; `r_bits_*`, `b_bits_*` = 0. `ar_ready` and `aw_ready` = 0 while `reset` is high, 1 on the first cycle after.
- AR handshake cycle N → first `r_valid` at N+1; with `r_ready` held high, beats at N+1 … N+1+len. Last R handshake at M → `ar_ready` at M+1.
- AW handshake at N → `w_ready` at N+1; last W handshake at M → `b_valid` at M+1; B handshake at K → `aw_ready` at K+1.
- Read and write handshakes may occur in the same cycle without interaction.

## Structure
- Package `axi4_mem_pkg`: `RESP_OKAY`/`RESP_SLVERR` constants, `r_state_t` and `w_state_t` enums, `beat_next_addr` function.
- Sub-module `axi4_mem_array`: `DEPTH_WORDS`×`DATA_BITS` storage, one byte-strobed write port and one registered read port with a load enable.

## Test plan
- Reset, then single read of word 0 after writing 0x0123_4567_89AB_CDEF with `strb`=0xFF → AR at N, `r_valid` at N+1, data matches, resp 0, `r_bits_last` 1.
- 4-beat write at 0x40 with `strb`=0x0F on beat 2, then 4-beat read → beat 2 upper bytes unchanged, B resp OKAY 1 cycle after last W.
- Read len=255 with `r_ready` toggled randomly → 256 beats, stable data during stalls, last only on beat 256, `ar_ready` 1 cycle after.
- Write at `DEPTH_WORDS*8−8` with len=1 → beat 2 dropped, B resp 2'b10; read of the same range → beat 2 data 0, resp 2'b10.
- Write len=3 with `w_bits_last` on beat 2 → 4 beats still accepted, B resp 2'b10.
- Assert `reset` mid read burst and mid write data → all valids 0, readies 1 after reset, earlier-written data intact.
